// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchronise/debounce/edge-detect of the mode and inc buttons.
// Optional macro AUTO_REPEAT_EN adds held-button auto-repeat on the inc channel.
`default_nettype none

module button_conditioner_chan #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic stay_held_o
);
  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    HELD         = 2'b10,
    RELEASE_WAIT = 2'b11
  } state_e;

  localparam logic [CNT_W:0]   DB_TARGET = (CNT_W+1)'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic             differ, hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // The state encoding keeps the debounced level in bit 1, so the level is a plain flop output.
  assign level_o = state_q[1];
  assign differ  = sync2_q ^ level_o;
  assign hit     = differ && (({1'b0, cnt_q} + 1'b1) == DB_TARGET);

  always_comb begin
    cnt_d = '0;
    if (differ && !hit) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (hit)          state_d = HELD;
        else if (sync2_q) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (hit)           state_d = HELD;
        else if (!sync2_q) state_d = IDLE;
      end
      HELD: begin
        if (hit)           state_d = IDLE;
        else if (!sync2_q) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (hit)          state_d = IDLE;
        else if (sync2_q) state_d = HELD;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rise_o      = hit && !level_o;
  assign stay_held_o = (state_q == HELD) && (state_d == HELD);
endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_RATE     = 8,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic mode_button_raw,
  input  logic inc_button_raw,
  output logic mode_pulse,
  output logic inc_pulse,
  output logic mode_level,
  output logic inc_level
);
  logic mode_rise, inc_rise, inc_stay_held, inc_repeat;
  logic mode_stay_held_unused;
  logic mode_pulse_q, inc_pulse_q;

  button_conditioner_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_mode (
    .clk_i      (clk),
    .rst_ni     (rst),
    .raw_i      (mode_button_raw),
    .level_o    (mode_level),
    .rise_o     (mode_rise),
    .stay_held_o(mode_stay_held_unused)
  );

  button_conditioner_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_inc (
    .clk_i      (clk),
    .rst_ni     (rst),
    .raw_i      (inc_button_raw),
    .level_o    (inc_level),
    .rise_o     (inc_rise),
    .stay_held_o(inc_stay_held)
  );

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W:0]   RPT_DELAY_T = (CNT_W+1)'(REPEAT_DELAY);
  localparam logic [CNT_W:0]   RPT_RATE_T  = (CNT_W+1)'(REPEAT_RATE);
  localparam logic [CNT_W-1:0] RPT_MAX     = '1;

  logic [CNT_W-1:0] rpt_q, rpt_d;
  logic             rpt_phase_q, rpt_phase_d;
  logic [CNT_W:0]   rpt_next, rpt_target;

  // Counter restarts whenever the inc channel is not settled in HELD; phase selects delay vs rate.
  always_comb begin
    rpt_d       = '0;
    rpt_phase_d = 1'b0;
    inc_repeat  = 1'b0;
    rpt_next    = {1'b0, rpt_q} + 1'b1;
    rpt_target  = rpt_phase_q ? RPT_RATE_T : RPT_DELAY_T;
    if (inc_stay_held) begin
      rpt_phase_d = rpt_phase_q;
      if (rpt_next == rpt_target) begin
        inc_repeat  = 1'b1;
        rpt_phase_d = 1'b1;
      end else begin
        rpt_d = (rpt_q == RPT_MAX) ? rpt_q : rpt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_q       <= '0;
      rpt_phase_q <= 1'b0;
    end else begin
      rpt_q       <= rpt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end
`else
  logic cfg_unused;
  assign inc_repeat = 1'b0;
  assign cfg_unused = ^{REPEAT_DELAY, REPEAT_RATE, inc_stay_held};
`endif

  // A coincident mode strobe wins; the inc strobe for that edge is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_pulse_q <= 1'b0;
      inc_pulse_q  <= 1'b0;
    end else begin
      mode_pulse_q <= mode_rise;
      inc_pulse_q  <= (inc_rise | inc_repeat) & ~mode_rise;
    end
  end

  assign mode_pulse = mode_pulse_q;
  assign inc_pulse  = inc_pulse_q;
endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: table-driven scoreboard bench for button_conditioner (default and DEBOUNCE_CYCLES=1).
`default_nettype none

module tb_button_conditioner;
  logic clk = 1'b0;
  logic rst;
  logic mode_raw, inc_raw;
  logic mode_pulse, inc_pulse, mode_level, inc_level;
  logic d1_mode_pulse, d1_inc_pulse, d1_mode_level, d1_inc_level;

  always #5 clk = ~clk;

  button_conditioner dut (
    .clk            (clk),
    .rst            (rst),
    .mode_button_raw(mode_raw),
    .inc_button_raw (inc_raw),
    .mode_pulse     (mode_pulse),
    .inc_pulse      (inc_pulse),
    .mode_level     (mode_level),
    .inc_level      (inc_level)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(1)) dut_d1 (
    .clk            (clk),
    .rst            (rst),
    .mode_button_raw(mode_raw),
    .inc_button_raw (inc_raw),
    .mode_pulse     (d1_mode_pulse),
    .inc_pulse      (d1_inc_pulse),
    .mode_level     (d1_mode_level),
    .inc_level      (d1_inc_level)
  );

  typedef struct {
    string      name;
    int         k;
    logic [3:0] exp_main;
    logic       chk_d1;
    logic [3:0] exp_d1;
  } sb_t;

  typedef struct {
    string       name;
    logic [63:0] m_raw;
    logic [63:0] i_raw;
    logic [63:0] m_pls;
    logic [63:0] i_pls;
    int          ml_r, ml_f, il_r, il_f;
  } vec_t;

  sb_t  sb[$];
  vec_t tbl[7];
  int   n_checks = 0;
  int   n_pass   = 0;

`ifdef AUTO_REPEAT_EN
  localparam logic [63:0] REP_MASK = 64'h0020_2020_0000_0020;
`else
  localparam logic [63:0] REP_MASK = 64'h0000_0000_0000_0020;
`endif

  function automatic vec_t mk(input string n, input logic [63:0] mr, input logic [63:0] ir,
                              input logic [63:0] mp, input logic [63:0] ip,
                              input int mlr, input int mlf, input int ilr, input int ilf);
    vec_t v;
    v.name = n; v.m_raw = mr; v.i_raw = ir; v.m_pls = mp; v.i_pls = ip;
    v.ml_r = mlr; v.ml_f = mlf; v.il_r = ilr; v.il_f = ilf;
    return v;
  endfunction

  function automatic logic lvl(input int k, input int r, input int f);
    return (k >= r) && (k < f);
  endfunction

  task automatic check(input string what, input int k, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s E%0d {mode_pulse,inc_pulse,mode_level,inc_level} got %b expected %b",
                  what, k, act, exp);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after rising edge Ek.
  task automatic step(input string name, input int k, input logic m, input logic i, input logic r,
                      input logic [3:0] exp_main, input logic chk_d1, input logic [3:0] exp_d1);
    sb_t e;
    @(negedge clk);
    mode_raw = m;
    inc_raw  = i;
    rst      = r;
    e.name = name; e.k = k; e.exp_main = exp_main; e.chk_d1 = chk_d1; e.exp_d1 = exp_d1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(e.name, e.k, {mode_pulse, inc_pulse, mode_level, inc_level}, e.exp_main);
    if (e.chk_d1)
      check({e.name, "/D1"}, e.k, {d1_mode_pulse, d1_inc_pulse, d1_mode_level, d1_inc_level}, e.exp_d1);
  endtask

  initial begin
    rst = 1'b0; mode_raw = 1'b0; inc_raw = 1'b0;

    for (int k = 0; k < 3; k++) step("reset", k, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000);
    for (int k = 0; k < 5; k++) step("idle", k, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000);

    tbl[0] = mk("clean_press",    64'h0,   64'h3FF,  64'h0,  64'h20,   99, 99, 5, 15);
    tbl[1] = mk("glitch_mode",    64'h7,   64'h0,    64'h0,  64'h0,    99, 99, 99, 99);
    tbl[2] = mk("bounce_press",   64'h0,   64'h3FF5, 64'h0,  64'h200,  99, 99, 9, 19);
    tbl[3] = mk("simultaneous",   64'h3FF, 64'h3FF,  64'h20, 64'h0,    5, 15, 5, 15);
    tbl[4] = mk("release_bounce", 64'h0,   64'hBFF,  64'h0,  64'h20,   99, 99, 5, 17);
    tbl[5] = mk("staggered",      64'h3C,  64'h3FF,  64'h80, 64'h20,   7, 11, 5, 15);
    tbl[6] = mk("held_repeat",    64'h0,   64'h000F_FFFF_FFFF_FFFF, 64'h0, REP_MASK, 99, 99, 5, 57);

    foreach (tbl[c]) begin
      for (int k = 0; k < 64; k++) begin
        step(tbl[c].name, k, tbl[c].m_raw[k], tbl[c].i_raw[k], 1'b1,
             {tbl[c].m_pls[k], tbl[c].i_pls[k], lvl(k, tbl[c].ml_r, tbl[c].ml_f), lvl(k, tbl[c].il_r, tbl[c].il_f)},
             1'b0, 4'b0000);
      end
    end

    // One-cycle press: rejected at the default debounce, a single pulse when DEBOUNCE_CYCLES=1.
    for (int k = 0; k < 8; k++) begin
      step("one_cycle_press", k, 1'b0, (k == 0), 1'b1, 4'b0000,
           1'b1, {1'b0, (k == 2), 1'b0, (k == 2)});
    end

    // Button held across an asynchronous reset pulse is re-debounced from the release.
    for (int k = 0; k < 41; k++) begin
      step("reset_mid_press", k, 1'b0, (k <= 20), !(k >= 3 && k <= 6),
           {1'b0, (k == 12), 1'b0, lvl(k, 12, 26)}, 1'b0, 4'b0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
    $fatal(1);
  end
endmodule

`default_nettype wire

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Sits directly upstream of the clock/alarm/stopwatch mode FSM and feeds it. Takes the raw, asynchronous mode and increment push-buttons and produces clean single-cycle mode_pulse and inc_pulse strobes, one per debounced press. The FSM consumes these strobes in place of raw button levels. Each channel has its own 2-flop synchronizer, debounce counter and edge detector. A cross-channel priority rule resolves coincident presses.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before the debounced level changes; legal range 1 to 2^CNT_W-1.
REPEAT_DELAY, 32, cycles from the first inc_pulse of a held press to the first auto-repeat pulse (AUTO_REPEAT_EN only).
REPEAT_RATE, 8, cycles between successive auto-repeat pulses (AUTO_REPEAT_EN only); must be ≥1.
CNT_W, 8, width of the debounce and repeat counters.

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous active-low reset
mode_button_raw  input  1  raw mode button, active-high, asynchronous
inc_button_raw  input  1  raw increment button, active-high, asynchronous
mode_pulse  output  1  one-cycle strobe per debounced mode press
inc_pulse  output  1  one-cycle strobe per debounced inc press (plus repeats if enabled)
mode_level  output  1  debounced mode button level
inc_level  output  1  debounced inc button level

Behaviour:
- Reset (rst=0, asynchronous): clears all of the following to 0.
  - Synchronizer flops, debounce counters, repeat counters.
  - mode_level, inc_level, mode_pulse, inc_pulse.
- Per channel:
  - The sync2 output is compared with the current debounced level.
  - If they differ, the counter increments. If they are equal, the counter clears to 0.
  - When the counter would reach DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
- Latency: let E0 be the first rising edge sampling raw=1, with raw held stable. The level rises and the pulse is high during the cycle after edge E0+DEBOUNCE_CYCLES+1. With the default of 4, that is after E5. Release follows the same latency for the level falling.
- The pulse is driven only by a 0→1 transition of the debounced level. Exactly one pulse per press, never more than one cycle wide. No pulse on release.
- Any raw glitch shorter than DEBOUNCE_CYCLES synchronized cycles: no level change, no pulse. This applies to bounce during press or release.
- DEBOUNCE_CYCLES=1: a raw press held for one full clock cycle still produces exactly one pulse.
- Simultaneous events: if mode and inc pulses would assert on the same edge, mode_pulse asserts and the inc pulse is dropped (not deferred). inc_level is unaffected.
- Per-channel state machine:
  - IDLE → PRESS_WAIT when sync2=1.
  - PRESS_WAIT → HELD when the counter hits DEBOUNCE_CYCLES (emit pulse). PRESS_WAIT → IDLE if sync2=0.
  - HELD → RELEASE_WAIT when sync2=0.
  - RELEASE_WAIT → IDLE when the counter hits DEBOUNCE_CYCLES. RELEASE_WAIT → HELD if sync2=1.
- Reset mid-operation: a button held across reset deassertion is treated as a new press. It is fully re-debounced from the first edge after deassertion and yields one pulse.
- Counter widths: counters saturate and never wrap.

Optional Feature:
Macro AUTO_REPEAT_EN.
- Defined, inc channel only:
  - While in HELD, a repeat counter starts at the initial pulse.
  - An extra inc_pulse is emitted REPEAT_DELAY cycles after the initial pulse, then every REPEAT_RATE cycles.
  - The repeat counter clears on leaving HELD. No repeat pulse is emitted on or after the edge where inc_level falls.
  - Mode priority still applies to repeats.
- Undefined: repeat logic is absent; one inc_pulse per press. The mode channel never repeats.

Test Plan:
- Clean press (defaults): inc raw high E0..E9 → inc_pulse high only after E5; inc_level high after E5, falls after E15; mode_pulse stays 0.
- Glitch rejection: mode raw high E0..E2 (3 cycles) → no mode_pulse, mode_level stays 0.
- Bounce: inc raw toggles 1,0,1,0, then stays 1 from E4 → exactly one inc_pulse, after E9.
- Simultaneous: both raw rise at E0 and hold 10 cycles → mode_pulse after E5, inc_pulse never asserts; inc_level still rises after E5.
- Reset mid-press: inc raw held from E0, rst low E3..E6 and released before E7 → no pulse before E7; one inc_pulse after E12; all outputs 0 during reset.
- Auto-repeat (AUTO_REPEAT_EN, defaults): inc raw high E0..E51 → inc_pulse after E5, E37, E45, E53 (4 pulses). With the macro undefined → only after E5.
